fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between the fetch stage and decode in the 64-bit LEGv8 pipeline.
- Fetch pushes {PC, 32-bit instruction} pairs as they return from instruction memory; decode pops them in order.
- First-word fall-through (FWFT) FIFO with a full backpressure signal to fetch and a flush on a taken branch (PCSrc).
- Decouples decode stalls from the fetch PC flop.

Parameters:
- N, 64, PC/address width.
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- push_F  in  1  fetch presents a valid instruction this cycle.
- pc_F  in  N  PC of the pushed instruction (fetch's imem_addr_F).
- instr_F  in  32  instruction word from instruction memory.
- full_F  out  1  queue holds DEPTH entries; fetch must hold its PC.
- pop_D  in  1  decode consumes the head entry this cycle.
- valid_D  out  1  head entry present.
- pc_D  out  N  PC of head entry.
- instr_D  out  32  instruction of head entry.
- flush  in  1  taken branch; discard all entries.
- count  out  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Storage: DEPTH entries of {pc, instr}; rd_ptr and wr_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Reset (clk edge with reset=1): rd_ptr=0, wr_ptr=0, count=0. valid_D=0, full_F=0, pc_D=0, instr_D=0. Entry contents need not be cleared.
- Outputs:
  - valid_D = (count!=0); full_F = (count==DEPTH).
  - pc_D/instr_D show the head entry combinationally when valid_D=1 and are forced to 0 when valid_D=0.
- Pop accepted iff pop_D && valid_D. Pop on an empty queue is ignored with no state change.
- Push accepted iff push_F && (!full_F || pop accepted in the same cycle). A push while full with no pop is dropped, and state is unchanged.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Push and pop on an empty queue in the same cycle: the push is accepted and the pop is ignored. The new entry becomes visible the next cycle (1-cycle latency from push to valid_D).
- Flush (priority above push/pop, below reset): next cycle rd_ptr=wr_ptr=0 and count=0. Any push or pop in the flush cycle is discarded.
- Ordering: strictly FIFO. pc_D sequence equals the accepted pc_F sequence since the last flush/reset.
- Single clock domain, no combinational path from pop_D to full_F (full_F depends only on count).
- Reset asserted mid-operation behaves exactly like reset from idle; in-flight entries are lost.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and push_F=1 and flush=0, the outputs show the incoming entry combinationally: valid_D=1, pc_D=pc_F, instr_D=instr_F.
  - If pop_D is also 1, the entry is consumed and not stored; count stays 0 and pointers are unchanged.
  - If pop_D=0, the entry is stored as normal.
  - Push-to-decode latency becomes 0 cycles when empty.
- Undefined: 1-cycle latency as described in Behaviour; no combinational path from push_F/pc_F/instr_F to the outputs.

Test Plan:
- Reset, then idle 3 cycles -> valid_D=0, full_F=0, count=0, pc_D=0, instr_D=0.
- Push PCs 0x0,0x4,0x8,0xC (instr 0xD2800020..23) with no pops -> count=4, full_F=1. A 5th push (0x10) is dropped. Pops then return 0x0,0x4,0x8,0xC in order, then valid_D=0.
- Wrap-around: 10 cycles of continuous push+pop after one prefill at 0x100 -> count stays 1. pc_D steps 0x100,0x104,... with no gaps; pointers wrap past DEPTH.
- Fill 3 entries, assert flush together with push of 0x200 -> next cycle count=0, valid_D=0. A following push of 0x400 appears at head with pc_D=0x400.
- Full queue, push 0x20 + pop same cycle -> push accepted, count stays 4, and 0x20 is popped last.
- Bypass on: empty queue, push 0x40 + pop same cycle -> valid_D=1 and pc_D=0x40 that same cycle, count stays 0. Bypass off: same stimulus -> valid_D=0 that cycle, count=1 next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: first-word fall-through prefetch buffer between LEGv8 fetch
// and decode. Fetch pushes {pc, instr} pairs, decode pops them in order, and
// a taken branch (flush) discards everything held.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// push is shown on the decode outputs in the same cycle. If decode also pops
// in that cycle, the entry is consumed and never stored.
module fetch_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_F,
    input  logic [N-1:0]             pc_F,
    input  logic [31:0]              instr_F,
    output logic                     full_F,
    input  logic                     pop_D,
    output logic                     valid_D,
    output logic [N-1:0]             pc_D,
    output logic [31:0]              instr_D,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    logic stored_valid;
    logic pop_acc;
    logic push_acc;
    logic bypass_hit;

    assign stored_valid = (count_q != '0);
    assign full_F       = (count_q == CW'(DEPTH));
    assign count        = count_q;
    assign pop_acc      = pop_D && stored_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = !stored_valid && push_F && !flush;
`else
    assign bypass_hit = 1'b0;
`endif

    // A push consumed directly by decode through the bypass is never stored
    assign push_acc = push_F && (!full_F || pop_acc) && !(bypass_hit && pop_D);

    // Pointer and occupancy register; flush empties the queue, reset wins over flush
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are not cleared since count gates visibility
    always_ff @(posedge clk) begin
        if (!reset && !flush && push_acc) begin
            pc_mem[wr_ptr]    <= pc_F;
            instr_mem[wr_ptr] <= instr_F;
        end
    end

    // Head presentation: stored head, else the bypassed incoming entry, else zeros
    always_comb begin
        valid_D = stored_valid;
        pc_D    = '0;
        instr_D = '0;
        if (stored_valid) begin
            pc_D    = pc_mem[rd_ptr];
            instr_D = instr_mem[rd_ptr];
        end else if (bypass_hit) begin
            valid_D = 1'b1;
            pc_D    = pc_F;
            instr_D = instr_F;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. The stimulus process keeps
// an abstract occupancy model and pushes every accepted entry onto an
// expected queue. A monitor on the falling edge compares the DUT head against
// that queue and retires entries as decode pops them.
module tb_fetch_queue;

    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } entry_t;

    logic          clk;
    logic          reset;
    logic          push_F;
    logic [N-1:0]  pc_F;
    logic [31:0]   instr_F;
    logic          full_F;
    logic          pop_D;
    logic          valid_D;
    logic [N-1:0]  pc_D;
    logic [31:0]   instr_D;
    logic          flush;
    logic [CW-1:0] count;

    entry_t exp_q[$];
    int     cur_cnt;
    int     nxt_cnt;
    int     checks;
    int     passes;

    fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .push_F  (push_F),
        .pc_F    (pc_F),
        .instr_F (instr_F),
        .full_F  (full_F),
        .pop_D   (pop_D),
        .valid_D (valid_D),
        .pc_D    (pc_D),
        .instr_D (instr_D),
        .flush   (flush),
        .count   (count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison with pass/fail bookkeeping
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model for that cycle
    task automatic applyStimulus(input logic rst, input logic push, input logic [N-1:0] pc,
                                 input logic [31:0] instr, input logic pop, input logic fl);
        bit pop_ok;
        bit push_ok;
        entry_t e;
        @(posedge clk);
        #1;
        cur_cnt = nxt_cnt;
        reset   = rst;
        push_F  = push;
        pc_F    = pc;
        instr_F = instr;
        pop_D   = pop;
        flush   = fl;
        e.pc    = pc;
        e.instr = instr;
        if (rst) begin
            exp_q.delete();
            nxt_cnt = 0;
        end else if (fl) begin
            exp_q.delete();
            nxt_cnt = 0;
        end else if (BYPASS && cur_cnt == 0 && push && pop) begin
            exp_q.push_back(e);
            nxt_cnt = 0;
        end else begin
            pop_ok  = pop && (cur_cnt > 0);
            push_ok = push && ((cur_cnt < DEPTH) || pop_ok);
            if (push_ok) exp_q.push_back(e);
            nxt_cnt = cur_cnt + int'(push_ok) - int'(pop_ok);
        end
    endtask

    // Monitor: status flags against model occupancy, head against scoreboard
    initial begin
        entry_t head;
        bit     exp_valid;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_valid = (cur_cnt != 0) || (BYPASS && push_F && !flush);
                checkOutput("count", 64'(count), 64'(cur_cnt));
                checkOutput("full_F", 64'(full_F), 64'(cur_cnt == DEPTH));
                checkOutput("valid_D", 64'(valid_D), 64'(exp_valid));
                if (!valid_D) begin
                    checkOutput("pc_D_idle", pc_D, 64'h0);
                    checkOutput("instr_D_idle", 64'(instr_D), 64'h0);
                end else if (!flush) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL head_present: got valid_D=1 pc_D=0x%0h expected empty scoreboard at %0t", pc_D, $time);
                    end else begin
                        head = exp_q[0];
                        checkOutput("pc_D", pc_D, head.pc);
                        checkOutput("instr_D", 64'(instr_D), 64'(head.instr));
                        if (pop_D) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int r;
        logic [N-1:0] rpc;
        checks  = 0;
        passes  = 0;
        cur_cnt = 0;
        nxt_cnt = 0;
        reset   = 1'b1;
        push_F  = 1'b0;
        pc_F    = '0;
        instr_F = '0;
        pop_D   = 1'b0;
        flush   = 1'b0;

        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 64'(4 * i), 32'hD2800020 + 32'(i), 0, 0);
        applyStimulus(0, 1, 64'h10, 32'hD2800024, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0);

        applyStimulus(0, 1, 64'h100, 32'hAA000100, 0, 0);
        for (int i = 1; i <= 10; i++) applyStimulus(0, 1, 64'h100 + 64'(4 * i), 32'hAA000100 + 32'(i), 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 64'h300 + 64'(4 * i), 32'hBB000000 + 32'(i), 0, 0);
        applyStimulus(0, 1, 64'h200, 32'hBB000200, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 64'h400, 32'hBB000400, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 64'h10 + 64'(4 * i), 32'hCC000000 + 32'(i), 0, 0);
        applyStimulus(0, 1, 64'h20, 32'hCC000020, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0);

        applyStimulus(0, 1, 64'h40, 32'hDD000040, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        rpc = 64'h1000;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                applyStimulus(1, 1, rpc, $urandom, 1, 0);
            end else if (r < 12) begin
                applyStimulus(0, $urandom_range(0, 1) == 1, rpc, $urandom, $urandom_range(0, 1) == 1, 1);
            end else begin
                applyStimulus(0, $urandom_range(0, 99) < 55, rpc, $urandom, $urandom_range(0, 99) < 50, 0);
            end
            rpc = rpc + 64'h4;
        end

        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
